// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache
// 2-way set-associative, write-back, write-allocate cache between a CPU
// load/store port and a word-wide memory with a ready handshake.
// Each set holds two ways (valid, dirty, tag, WORDS_PER_LINE words) and one
// LRU bit naming the way to evict next. Misses are served by an optional
// dirty-line writeback burst followed by a refill burst, then the held
// request completes as a hit.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   cpu_addr            : CPU byte address (bits [1:0] ignored)
//   cpu_write_data      : store data
//   cpu_read/cpu_write  : load/store request (store wins if both)
//   cpu_read_data       : load data, valid in the hit cycle
//   cpu_stall           : hold the CPU pipeline (miss or burst in progress)
//   hit                 : request hits in the current cycle
//   mem_addr            : memory byte address of the current beat
//   mem_write_data      : writeback beat data
//   mem_read/mem_write  : refill / writeback burst in progress
//   mem_read_data       : refill beat data
//   mem_ready           : beat accepted / read data valid
//   hit_count/miss_count: saturating statistics counters
module set_assoc_wb_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic                  cpu_stall,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(SETS);
    localparam int TB = DATA_WIDTH - 2 - WB - IB;
    // Beat counter is at least one bit wide even for single-word lines.
    localparam int BW = (WB > 0) ? WB : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]       valid_q [2];
    logic [SETS-1:0]       dirty_q [2];
    logic [SETS-1:0]       lru_q;
    logic [TB-1:0]         tag_q   [2][SETS];
    logic [DATA_WIDTH-1:0] data_q  [2][SETS][WORDS_PER_LINE];

    logic [BW-1:0] beat_q;
    logic [IB-1:0] lat_index_q;
    logic [TB-1:0] lat_tag_q;
    logic          victim_q;
    logic          refilled_q;
    logic [31:0]   hit_count_q;
    logic [31:0]   miss_count_q;

    logic [BW-1:0] word_s;
    logic [IB-1:0] index_s;
    logic [TB-1:0] tag_s;
    logic [1:0]    way_hit_s;
    logic          hit_way_s;
    logic          req_s;
    logic          idle_s;
    logic          miss_s;
    logic          victim_s;
    logic          victim_dirty_s;
    logic          last_beat_s;
    logic          refill_done_s;
    logic [TB-1:0] addr_tag_s;
    logic          unused_s;

    // Address decode: byte offset dropped, then word select, index, tag.
    assign word_s   = (WB > 0) ? cpu_addr[2 +: BW] : '0;
    assign index_s  = cpu_addr[2 + WB +: IB];
    assign tag_s    = cpu_addr[DATA_WIDTH-1 -: TB];
    assign unused_s = ^cpu_addr[1:0];

    assign way_hit_s[0] = valid_q[0][index_s] && (tag_q[0][index_s] == tag_s);
    assign way_hit_s[1] = valid_q[1][index_s] && (tag_q[1][index_s] == tag_s);
    assign hit_way_s    = ~way_hit_s[0];
    assign req_s        = cpu_read | cpu_write;
    assign idle_s       = (state_q == S_IDLE);
    assign hit          = req_s & idle_s & (|way_hit_s);
    assign miss_s       = req_s & idle_s & ~(|way_hit_s);

    assign cpu_read_data = data_q[hit_way_s][index_s][word_s];
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

    assign last_beat_s   = (beat_q == LAST_BEAT);
    assign refill_done_s = (state_q == S_REFILL) && mem_ready && last_beat_s;

    // Victim choice: fill invalid ways first, otherwise evict the LRU way.
    always_comb begin
        victim_s = 1'b0;
        if (!valid_q[0][index_s]) begin
            victim_s = 1'b0;
        end else if (!valid_q[1][index_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_q[index_s];
        end
    end

    assign victim_dirty_s = valid_q[victim_s][index_s] & dirty_q[victim_s][index_s];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a burst only advances on accepted beats.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (miss_s) begin
                    state_d = victim_dirty_s ? S_WRITEBACK : S_REFILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                if (mem_ready && last_beat_s) begin
                    state_d = S_REFILL;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_REFILL: begin
                if (mem_ready && last_beat_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Writeback addresses use the victim's stored tag, refills the latched tag.
    assign addr_tag_s = (state_q == S_WRITEBACK) ? tag_q[victim_q][lat_index_q] : lat_tag_q;

    // Output logic: memory strobes, burst address/data and CPU stall.
    always_comb begin
        mem_read       = (state_q == S_REFILL);
        mem_write      = (state_q == S_WRITEBACK);
        cpu_stall      = miss_s | ~idle_s;
        mem_write_data = data_q[victim_q][lat_index_q][beat_q];
        mem_addr       = (DATA_WIDTH'(addr_tag_s) << (IB + WB + 2))
                       | (DATA_WIDTH'(lat_index_q) << (WB + 2));
        if (WB > 0) begin
            mem_addr = mem_addr | (DATA_WIDTH'(beat_q) << 2);
        end else begin
            mem_addr = mem_addr;
        end
    end

    // Burst control: beat counter, miss context latch, post-refill marker.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_q      <= '0;
            lat_index_q <= '0;
            lat_tag_q   <= '0;
            victim_q    <= 1'b0;
            refilled_q  <= 1'b0;
        end else begin
            if (!idle_s && mem_ready) begin
                beat_q <= last_beat_s ? '0 : beat_q + BW'(1);
            end
            if (miss_s) begin
                lat_index_q <= index_s;
                lat_tag_q   <= tag_s;
                victim_q    <= victim_s;
            end
            refilled_q <= refill_done_s;
        end
    end

    // Line state: valid/dirty/LRU updated by refill completion and hits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else if (refill_done_s) begin
            valid_q[victim_q][lat_index_q] <= 1'b1;
            dirty_q[victim_q][lat_index_q] <= 1'b0;
            lru_q[lat_index_q]             <= ~victim_q;
        end else if (hit) begin
            lru_q[index_s] <= ~hit_way_s;
            if (cpu_write) begin
                dirty_q[hit_way_s][index_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: refill beats, tag on completion, store hits.
    always_ff @(posedge clk) begin
        if ((state_q == S_REFILL) && mem_ready) begin
            data_q[victim_q][lat_index_q][beat_q] <= mem_read_data;
        end
        if (refill_done_s) begin
            tag_q[victim_q][lat_index_q] <= lat_tag_q;
        end
        if (hit && cpu_write) begin
            data_q[hit_way_s][index_s][word_s] <= cpu_write_data;
        end
    end

    // Statistics: the replayed hit right after a refill is not a new hit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if (miss_s && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
            if (hit && !refilled_q && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Self-checking bench for set_assoc_wb_cache (SETS=4, WORDS_PER_LINE=4).
// A vector table drives CPU accesses; expected memory beats are queued on
// issue and matched by a monitor as the cache produces them.
module tb_set_assoc_wb_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
    logic        cpu_read, cpu_write, cpu_stall, hit;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write, mem_ready;
    logic [31:0] hit_count, miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        bit          chk;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall;
        bit          wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_d0;
        bit          rf;
        logic [31:0] rf_addr;
        int          hits;
        int          misses;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    // Backing memory contents: line 0x100 holds 0xA0+beat, others a tagged pattern.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a[31:4] == 28'h0000010) return 32'h000000A0 + {30'd0, a[3:2]};
        return 32'hC0DE0000 | {16'd0, a[15:0]};
    endfunction

    assign mem_read_data = mem_init(mem_addr);

    set_assoc_wb_cache #(.DATA_WIDTH(32), .SETS(4), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall), .hit(hit),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory-side monitor: every accepted beat must match the queue head.
    always @(negedge clk) begin
        txn_t e;
        if (mem_read && mem_write) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_rd_wr_excl: got both high expected one-hot");
        end
        if ((mem_read || mem_write) && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mem_unexpected: got beat at %h expected none", mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("mem_is_write", {31'd0, mem_write}, {31'd0, e.wr});
                check("mem_addr", mem_addr, e.addr);
                if (e.wr) check("mem_wdata", mem_write_data, e.data);
            end
        end
    end

    function automatic vec_t mkv(bit rst, bit rd, bit wr, bit chk,
                                 logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                 int stall, bit wb, logic [31:0] wb_addr, logic [31:0] wb_d0,
                                 bit rf, logic [31:0] rf_addr, int hits, int misses);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.chk = chk;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.stall = stall;
        v.wb = wb; v.wb_addr = wb_addr; v.wb_d0 = wb_d0;
        v.rf = rf; v.rf_addr = rf_addr; v.hits = hits; v.misses = misses;
        return v;
    endfunction

    task automatic reset_dut();
        reset = 1'b0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic push_refill(input logic [31:0] base);
        txn_t t;
        for (int b = 0; b < 4; b++) begin
            t.wr = 1'b0; t.addr = base + 32'(4 * b); t.data = 32'd0;
            exp_q.push_back(t);
        end
    endtask

    task automatic apply(input vec_t v);
        int  stalls;
        bit  done;
        txn_t t;
        @(posedge clk);
        #1;
        if (v.wb) begin
            for (int b = 0; b < 4; b++) begin
                t.wr = 1'b1;
                t.addr = v.wb_addr + 32'(4 * b);
                t.data = (b == 0) ? v.wb_d0 : mem_init(t.addr);
                exp_q.push_back(t);
            end
        end
        if (v.rf) push_refill(v.rf_addr);
        cpu_addr = v.addr;
        cpu_write_data = v.wdata;
        cpu_read = v.rd;
        cpu_write = v.wr;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (cpu_stall) begin
                if (c == 0) check("miss_hit_low", {31'd0, hit}, 32'd0);
                stalls++;
            end else begin
                check("hit_high", {31'd0, hit}, 32'd1);
                if (v.chk) check("rdata", cpu_read_data, v.rdata);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: got stall at %h expected release", v.addr);
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        check("stall_cycles", 32'(stalls), 32'(v.stall));
        @(negedge clk);
        check("hit_count", hit_count, 32'(v.hits));
        check("miss_count", miss_count, 32'(v.misses));
    endtask

    initial begin
        bit done;
        // rst rd wr chk addr wdata rdata stall wb wb_addr wb_d0 rf rf_addr hits misses
        vecs[0]  = mkv(1, 1, 0, 1, 32'h100, 32'h0, 32'h000000A0, 5, 0, 32'h0, 32'h0, 1, 32'h100, 0, 1);
        vecs[1]  = mkv(0, 1, 0, 1, 32'h108, 32'h0, 32'h000000A2, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1);
        vecs[2]  = mkv(0, 0, 1, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2, 1);
        vecs[3]  = mkv(0, 1, 0, 1, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0, 32'h0, 3, 1);
        vecs[4]  = mkv(0, 1, 1, 0, 32'h10C, 32'h77, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 4, 1);
        vecs[5]  = mkv(0, 1, 0, 1, 32'h10C, 32'h0, 32'h77, 0, 0, 32'h0, 32'h0, 0, 32'h0, 5, 1);
        vecs[6]  = mkv(1, 1, 0, 1, 32'h000, 32'h0, 32'hC0DE0000, 5, 0, 32'h0, 32'h0, 1, 32'h000, 0, 1);
        vecs[7]  = mkv(0, 1, 0, 1, 32'h040, 32'h0, 32'hC0DE0040, 5, 0, 32'h0, 32'h0, 1, 32'h040, 0, 2);
        vecs[8]  = mkv(0, 1, 0, 1, 32'h000, 32'h0, 32'hC0DE0000, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 2);
        vecs[9]  = mkv(0, 1, 0, 1, 32'h080, 32'h0, 32'hC0DE0080, 5, 0, 32'h0, 32'h0, 1, 32'h080, 1, 3);
        vecs[10] = mkv(0, 1, 0, 1, 32'h000, 32'h0, 32'hC0DE0000, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2, 3);
        vecs[11] = mkv(0, 1, 0, 1, 32'h040, 32'h0, 32'hC0DE0040, 5, 0, 32'h0, 32'h0, 1, 32'h040, 2, 4);
        vecs[12] = mkv(1, 0, 1, 0, 32'h040, 32'h55, 32'h0, 5, 0, 32'h0, 32'h0, 1, 32'h040, 0, 1);
        vecs[13] = mkv(0, 1, 0, 1, 32'h080, 32'h0, 32'hC0DE0080, 5, 0, 32'h0, 32'h0, 1, 32'h080, 0, 2);
        vecs[14] = mkv(0, 1, 0, 1, 32'h0C0, 32'h0, 32'hC0DE00C0, 9, 1, 32'h040, 32'h55, 1, 32'h0C0, 0, 3);
        vecs[15] = mkv(0, 1, 0, 1, 32'h048, 32'h0, 32'hC0DE0048, 5, 0, 32'h0, 32'h0, 1, 32'h040, 0, 4);

        cpu_addr = 32'd0;
        cpu_write_data = 32'd0;
        reset_dut();

        // Idle state straight out of reset.
        @(negedge clk);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) reset_dut();
            apply(vecs[i]);
        end

        // Refill beat 2 held off for three cycles.
        reset_dut();
        @(posedge clk);
        #1;
        push_refill(32'h100);
        cpu_addr = 32'h100;
        cpu_read = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ready_low_addr", mem_addr, 32'h108);
            check("ready_low_stall", {31'd0, cpu_stall}, 32'd1);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                check("ready_low_rdata", cpu_read_data, 32'h000000A0);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_low_timeout: got stall expected release");
        end
        @(posedge clk);
        #1 cpu_read = 1'b0;
        apply(mkv(0, 1, 0, 1, 32'h108, 32'h0, 32'h000000A2, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1));

        // Reset asserted while refill beat 1 is on the bus.
        reset_dut();
        @(posedge clk);
        #1;
        exp_q.push_back('{1'b0, 32'h100, 32'h0});
        exp_q.push_back('{1'b0, 32'h104, 32'h0});
        cpu_addr = 32'h100;
        cpu_read = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("abort_mem_write", {31'd0, mem_write}, 32'd0);
        check("abort_stall", {31'd0, cpu_stall}, 32'd0);
        check("abort_hit_count", hit_count, 32'd0);
        check("abort_miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        apply(mkv(0, 1, 0, 1, 32'h100, 32'h0, 32'h000000A0, 5, 0, 32'h0, 32'h0, 1, 32'h100, 0, 1));

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
